// File: rtl/mem_bit_capture_pkg.sv
// Shared types and sizes for the serial-bit capture memory.
package mem_bit_capture_pkg;

    localparam int unsigned MEM_DEPTH = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned BIT_IDX_W = $clog2(BYTE_W);
    localparam int unsigned TIMER_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bit_capture_tick.sv
// Free-running divider: asserts tick_c for one cycle every TICK_DIV enabled cycles.
module tick_gen
    import mem_bit_capture_pkg::*;
#(
    parameter int unsigned TICK_DIV = 2
)
(
    input  logic clock_50Mhz,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick_c
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TICK_DIV - 1);

    logic [TIMER_W-1:0] timer;

    assign tick_c = enable && (timer == LAST);

    // Timer only advances while enabled so the first tick lands TICK_DIV cycles after a clear.
    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable) begin
            if (timer == LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + TIMER_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_bit_capture.sv
// Samples bit_in once per tick, packs bytes LSB-first into a 32 x 8 register memory, parallel read port.
module mem_bit_capture
    import mem_bit_capture_pkg::*;
#(
    parameter int unsigned TICK_DIV = 32'd50_000_000
)
(
    input  logic              clock_50Mhz,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              byte_strobe,
    output logic [CNT_W-1:0]  wr_count,
    output logic              led
);

    state_t                 state;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [ADDR_W-1:0]      wr_addr;
    logic [BYTE_W-1:0]      assembler;
    logic [BYTE_W-1:0]      mem [MEM_DEPTH];

    logic                   tick_c;
    logic                   capture_c;
    logic                   start_accept_c;
    logic                   byte_wr_c;
    logic [BYTE_W-1:0]      byte_next_c;

    assign capture_c      = (state == ST_CAPTURE);
    assign start_accept_c = start && !capture_c;
    assign byte_next_c    = {bit_in, assembler[BYTE_W-1:1]};
    assign byte_wr_c      = capture_c && tick_c && (bit_idx == BIT_IDX_W'(BYTE_W - 1));

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock_50Mhz (clock_50Mhz),
        .reset       (reset),
        .enable      (capture_c),
        .clear       (start_accept_c),
        .tick_c      (tick_c)
    );

    // Capture control: start handshake, bit/byte bookkeeping and status outputs.
    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            wr_addr     <= '0;
            wr_count    <= '0;
            assembler   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            byte_strobe <= 1'b0;
            led         <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_CAPTURE;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        bit_idx   <= '0;
                        wr_addr   <= '0;
                        wr_count  <= '0;
                        assembler <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (tick_c) begin
                        led       <= bit_in;
                        assembler <= byte_next_c;
                        bit_idx   <= bit_idx + BIT_IDX_W'(1);
                        if (byte_wr_c) begin
                            wr_addr     <= wr_addr + ADDR_W'(1);
                            wr_count    <= wr_count + CNT_W'(1);
                            byte_strobe <= 1'b1;
                            if (wr_count == CNT_W'(MEM_DEPTH - 1)) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Register memory; non-blocking read alongside the write gives read-before-write.
    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
            if (byte_wr_c) begin
                mem[wr_addr] <= byte_next_c;
            end
        end
    end

endmodule

// File: tb/tb_mem_bit_capture.sv
// Scoreboard bench for mem_bit_capture with TICK_DIV=4: queued read and byte-strobe expectations.
module tb_mem_bit_capture;

    localparam int unsigned TICK_DIV = 4;

    logic       clock_50Mhz = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       start;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       byte_strobe;
    logic [5:0] wr_count;
    logic       led;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rd_q[$];
    int unsigned cnt_q[$];
    logic        rd_req   = 1'b0;
    logic        rd_req_d = 1'b0;

    always #10 clock_50Mhz = ~clock_50Mhz;

    mem_bit_capture #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clock_50Mhz (clock_50Mhz),
        .reset       (reset),
        .bit_in      (bit_in),
        .start       (start),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .byte_strobe (byte_strobe),
        .wr_count    (wr_count),
        .led         (led)
    );

    always @(posedge clock_50Mhz) rd_req_d <= rd_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever a read result or byte strobe is presented.
    always @(negedge clock_50Mhz) begin
        if (rd_req_d) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no read at %0t", rd_data, $time);
            end else begin
                check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
        end
        if (byte_strobe) begin
            if (cnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe_unexpected: got wr_count %0d expected no strobe at %0t", wr_count, $time);
            end else begin
                check("strobe_wr_count", 32'(wr_count), cnt_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [4:0] a, input logic [7:0] e);
        rd_addr = a;
        rd_req  = 1'b1;
        rd_q.push_back(e);
        @(negedge clock_50Mhz);
        rd_req  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock_50Mhz);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pulse);
        for (int i = 0; i < 8; i++) begin
            bit_in = b[i];
            if (pulse) begin
                start = 1'b1;
                @(negedge clock_50Mhz);
                start = 1'b0;
                repeat (3) @(negedge clock_50Mhz);
            end else begin
                repeat (4) @(negedge clock_50Mhz);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        bit_in  = 1'b0;
        rd_addr = '0;
        repeat (3) @(negedge clock_50Mhz);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_led", 32'(led), 0);
        check("rst_strobe", 32'(byte_strobe), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        reset = 1'b0;

        // Idle: nothing moves, memory reads back cleared.
        repeat (20) @(negedge clock_50Mhz);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_led", 32'(led), 0);
        for (int a = 0; a < 32; a++) rd(5'(a), 8'h00);
        @(negedge clock_50Mhz);

        // Single byte 0x55, first tick exactly TICK_DIV cycles after acceptance.
        do_start();
        check("start_busy", 32'(busy), 1);
        cnt_q.push_back(1);
        bit_in = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clock_50Mhz);
            check("led_before_tick", 32'(led), 0);
        end
        @(negedge clock_50Mhz);
        check("led_first_tick", 32'(led), 1);
        for (int i = 1; i < 8; i++) begin
            bit_in = (i % 2 == 0);
            repeat (4) @(negedge clock_50Mhz);
        end
        check("b55_wr_count", 32'(wr_count), 1);
        check("b55_busy", 32'(busy), 1);
        rd(5'd0, 8'h55);
        @(negedge clock_50Mhz);
        reset = 1'b1;
        @(negedge clock_50Mhz);
        reset = 1'b0;

        // Full capture of 0x00..0x1F.
        do_start();
        for (int b = 0; b < 32; b++) begin
            cnt_q.push_back(b + 1);
            send_byte(8'(b), 1'b0);
            if (b == 30) check("pre_last_done", 32'(done), 0);
        end
        check("full_done", 32'(done), 1);
        check("full_busy", 32'(busy), 0);
        check("full_wr_count", 32'(wr_count), 32);
        repeat (40) @(negedge clock_50Mhz);
        check("done_hold_count", 32'(wr_count), 32);
        check("done_hold_done", 32'(done), 1);
        for (int a = 0; a < 32; a++) rd(5'(a), 8'(a));
        @(negedge clock_50Mhz);

        // Restart from DONE, with start hammered during CAPTURE.
        do_start();
        check("restart_busy", 32'(busy), 1);
        check("restart_done", 32'(done), 0);
        check("restart_wr_count", 32'(wr_count), 0);
        cnt_q.push_back(1);
        send_byte(8'hFF, 1'b1);
        fork
            begin
                cnt_q.push_back(2);
                send_byte(8'h3C, 1'b1);
            end
            begin
                rd(5'd0, 8'hFF);
                for (int a = 1; a < 13; a++) rd(5'(a), 8'(a));
                rd_addr = 5'd0;
            end
        join
        check("mid_done", 32'(done), 0);
        check("mid_wr_count", 32'(wr_count), 2);
        for (int b = 2; b < 32; b++) begin
            cnt_q.push_back(b + 1);
            send_byte(8'(b), 1'b1);
        end
        check("rerun_done", 32'(done), 1);
        check("rerun_wr_count", 32'(wr_count), 32);
        rd(5'd0, 8'hFF);
        rd(5'd1, 8'h3C);
        for (int a = 2; a < 32; a++) rd(5'(a), 8'(a));
        @(negedge clock_50Mhz);

        // Asynchronous reset after 13 ticks, then a fresh 0xA5 capture.
        do_start();
        cnt_q.push_back(1);
        send_byte(8'hFF, 1'b0);
        bit_in = 1'b1;
        repeat (20) @(negedge clock_50Mhz);
        #3 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_led", 32'(led), 0);
        check("arst_wr_count", 32'(wr_count), 0);
        check("arst_rd_data", 32'(rd_data), 0);
        @(negedge clock_50Mhz);
        reset = 1'b0;
        @(negedge clock_50Mhz);
        do_start();
        cnt_q.push_back(1);
        send_byte(8'hA5, 1'b0);
        check("a5_led", 32'(led), 1);
        check("a5_wr_count", 32'(wr_count), 1);
        rd(5'd0, 8'hA5);
        rd(5'd1, 8'h00);
        rd(5'd2, 8'h00);
        repeat (2) @(negedge clock_50Mhz);

        check("rd_q_drained", 32'(rd_q.size()), 0);
        check("cnt_q_drained", 32'(cnt_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bit_capture.md
MEM_BIT_CAPTURE -- requirements
Module: mem_bit_capture

Interface
REQ-001 Parameter TICK_DIV, default 32'd50_000_000, clock cycles per bit-sample tick (minimum 2).
REQ-002 clock_50Mhz  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 bit_in  in  1  serial data bit, sampled once per tick.
REQ-005 start  in  1  one-cycle request to begin a 32-byte capture.
REQ-006 rd_addr  in  5  read address into the capture memory.
REQ-007 rd_data  out  8  registered read data.
REQ-008 busy  out  1  high while in CAPTURE.
REQ-009 done  out  1  high while in DONE.
REQ-010 byte_strobe  out  1  one-cycle pulse on each completed byte write.
REQ-011 wr_count  out  6  bytes written in the current capture, 0..32.
REQ-012 led  out  1  copy of the most recently sampled bit.

Function
REQ-013 The block SHALL hold a 32 x 8-bit memory, write side filled serially, read side parallel.
REQ-014 The FSM SHALL have states IDLE, CAPTURE and DONE, with IDLE the reset state.
REQ-015 Transitions: start=1 in IDLE or DONE -> CAPTURE on the next edge; 32nd byte written -> DONE; start in CAPTURE -> ignored.
REQ-016 On start acceptance: timer, bit index, write address and wr_count SHALL clear to 0; done SHALL drop on the same edge busy rises.
REQ-017 The tick timer SHALL count 0..TICK_DIV-1 and wrap only in CAPTURE; a tick is timer==TICK_DIV-1, first tick TICK_DIV cycles after start acceptance.
REQ-018 On each tick, bit_in SHALL be shifted into the byte assembler LSB-first (first sampled bit -> bit 0), and led SHALL take bit_in.
REQ-019 On the tick carrying bit index 7, the assembled byte SHALL be written to mem[wr_addr]; wr_addr increments; wr_count increments; byte_strobe pulses on the following cycle.
REQ-020 Bit index SHALL wrap 7->0 and wr_addr 31->0, with no gap ticks between bytes.
REQ-021 After the 32nd write, wr_count SHALL read 32 and the FSM SHALL enter DONE on that edge; no further samples are taken.
REQ-022 The read port SHALL have 1-cycle latency: rd_data at edge n+1 = mem[rd_addr at edge n], in every state.
REQ-023 A read of the address being written on the same edge SHALL return the old contents (read-before-write).
REQ-024 Memory contents SHALL persist across DONE->CAPTURE restarts until overwritten.
REQ-025 All arithmetic SHALL be unsigned; the timer width SHALL be 32 bits.

Reset
REQ-026 While reset=1 (asynchronous assert): state=IDLE, timer=0, bit index=0, wr_addr=0, wr_count=0, assembler=0.
REQ-027 Reset values of outputs: rd_data=0, busy=0, done=0, byte_strobe=0, led=0.
REQ-028 Every memory byte SHALL clear to 8'h00 on reset.
REQ-029 Reset mid-capture SHALL discard the partial byte; no write occurs.

Structure
REQ-030 Shared package: FSM state encodings (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2), MEM_DEPTH=32, BYTE_W=8.
REQ-031 One sub-module SHALL be used: tick_gen (parameterised timer emitting a 1-cycle tick, with sync clear).
REQ-032 Target size 120-400 lines RTL; no vendor primitives; memory inferred as registers.

Verification (TICK_DIV=4)
REQ-033 Reset, then idle 20 cycles -> busy=0, done=0, led=0, rd_data=0 for all 32 addresses.
REQ-034 start, bit_in pattern 1,0,1,0,1,0,1,0 held per tick -> mem[0]=8'h55, byte_strobe once, wr_count=1, first tick at cycle 4 after acceptance.
REQ-035 start, stream bytes 8'h00..8'h1F LSB-first -> done after 256 ticks; reading addresses 0..31 returns 0..31; wr_count=32.
REQ-036 Assert start repeatedly during CAPTURE -> no restart; wr_count sequence unaffected.
REQ-037 reset pulse after 13 ticks, then new capture of 8'hA5 -> mem[0]=8'hA5, no remnant of the partial byte.
REQ-038 In DONE, start with bit_in=1 for 8 ticks -> mem[0]=8'hFF, mem[1..31] keep prior values, done low during CAPTURE.
